ram_pipe: RTL

RAM_PIPE -- requirements
Module: ram_pipe

---
 rtl/ram_pipe.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ram_pipe.sv
// Single-port-pair RAM with lane-masked writes, write-first read bypass and a
// fixed-latency read pipeline; optionally zero-fills itself after reset.
module ram_pipe #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int MASK_WIDTH     = 2,
    parameter int RD_LATENCY     = 2,
    parameter     RAM_TYPE       = "block",
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  s_ready,
    input  logic                  s_read_req,
    input  logic [ADDR_WIDTH-1:0] s_read_addr,
    output logic [DATA_WIDTH-1:0] s_read_data,
    output logic                  s_read_valid,
    input  logic                  s_write_req,
    input  logic [ADDR_WIDTH-1:0] s_write_addr,
    input  logic [DATA_WIDTH-1:0] s_write_data,
    input  logic [MASK_WIDTH-1:0] s_write_mask
);

    localparam int LANE_W = DATA_WIDTH / MASK_WIDTH;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic                    ready_q, ready_d;

    logic                    rd_acc_s;
    logic                    wr_acc_s;
    logic [MASK_WIDTH-1:0]   mem_we_s;
    logic [ADDR_WIDTH-1:0]   mem_waddr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;
    logic [DATA_WIDTH-1:0]   rd_raw_s;
    logic [DATA_WIDTH-1:0]   rd_merged_s;

    logic [RD_LATENCY-1:0]   vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [RD_LATENCY];

    // Next-state logic: CLEAR walks every address exactly once, then parks in READY
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_READY;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d    = RESET_STATE;
                clr_addr_d = '0;
            end
        endcase
        ready_d = (state_d == ST_READY);
    end

    // State, clear counter and ready flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RESET_STATE;
            clr_addr_q <= '0;
            ready_q    <= !CLEAR_ON_RESET;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
        end
    end

    // Write-port steering: the clear sweep owns the port while it runs
    always_comb begin
        rd_acc_s    = s_read_req & ready_q;
        wr_acc_s    = s_write_req & ready_q;
        mem_waddr_s = s_write_addr;
        mem_wdata_s = s_write_data;
        if (state_q == ST_CLEAR) begin
            mem_waddr_s = clr_addr_q;
            mem_wdata_s = '0;
            mem_we_s    = '1;
        end else if (wr_acc_s) begin
            mem_we_s    = s_write_mask;
        end else begin
            mem_we_s    = '0;
        end
    end

    // Write-first bypass: a same-address write overrides only its enabled lanes
    always_comb begin
        rd_merged_s = rd_raw_s;
        for (int l = 0; l < MASK_WIDTH; l++) begin
            if (wr_acc_s && s_write_mask[l] && (s_write_addr == s_read_addr)) begin
                rd_merged_s[l*LANE_W +: LANE_W] = s_write_data[l*LANE_W +: LANE_W];
            end else begin
                rd_merged_s[l*LANE_W +: LANE_W] = rd_raw_s[l*LANE_W +: LANE_W];
            end
        end
    end

    generate
        if (RAM_TYPE == "block") begin : g_mem
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

            // Lane-masked storage write; contents are never touched by reset
            always_ff @(posedge clk) begin
                for (int l = 0; l < MASK_WIDTH; l++) begin
                    if (mem_we_s[l]) begin
                        mem[mem_waddr_s][l*LANE_W +: LANE_W] <= mem_wdata_s[l*LANE_W +: LANE_W];
                    end
                end
            end

            assign rd_raw_s = mem[s_read_addr];
        end else begin : g_mem
            (* ram_style = RAM_TYPE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

            // Lane-masked storage write; contents are never touched by reset
            always_ff @(posedge clk) begin
                for (int l = 0; l < MASK_WIDTH; l++) begin
                    if (mem_we_s[l]) begin
                        mem[mem_waddr_s][l*LANE_W +: LANE_W] <= mem_wdata_s[l*LANE_W +: LANE_W];
                    end
                end
            end

            assign rd_raw_s = mem[s_read_addr];
        end
    endgenerate

    // Read pipeline: data is captured at the accepting edge, so later writes cannot disturb it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc_s;
            if (rd_acc_s) begin
                dat_q[0] <= rd_merged_s;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
    end

    assign s_ready      = ready_q;
    assign s_read_valid = vld_q[RD_LATENCY-1];
    assign s_read_data  = dat_q[RD_LATENCY-1];

endmodule
